// File: rtl/mult_unit_pkg.sv
// Shared definitions for the sequential multiplier: FSM encodings, default
// operand width and the HI/LO result-mux select codes used by the datapath.
package mult_unit_pkg;

  localparam int MULT_WIDTH = 32;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_CALC = 2'd1,
    MS_FIN  = 2'd2
  } mult_state_t;

  // Datapath result-mux selects for MFHI / MFLO
  localparam logic [2:0] OUTSEL_HI = 3'd4;
  localparam logic [2:0] OUTSEL_LO = 3'd5;

endpackage

// File: rtl/mult_unit_if.sv
// Controller <-> multiplier bus. The controller only raises start_mult while
// mult_busy is low; a start seen while busy is dropped, never queued.
interface mult_unit_if
  import mult_unit_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) ();

  logic             start_mult;
  logic             mult_sign;
  logic [WIDTH-1:0] srca;
  logic [WIDTH-1:0] srcb;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             mult_busy;
  logic             mult_done;

  modport master (
    output start_mult, mult_sign, srca, srcb,
    input  hi, lo, mult_busy, mult_done
  );

  modport slave (
    input  start_mult, mult_sign, srca, srcb,
    output hi, lo, mult_busy, mult_done
  );

endinterface

// File: rtl/mult_unit.sv
// Radix-2 shift-add 32x32 multiplier: signed operands are reduced to
// magnitudes up front and the sign is reapplied to the product in FIN.
module mult_unit
  import mult_unit_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic        clk,
  input  logic        reset,
  mult_unit_if.slave  bus,
  output mult_state_t dbg_state
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam int PW    = 2 * WIDTH;

  mult_state_t      state;
  mult_state_t      next_state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]    acc;
  logic [CNT_W-1:0] count;
  logic             neg;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;
  logic [WIDTH:0]   sum;

  // Upper-half add keeps its carry so the right shift below loses nothing
  assign sum = {1'b0, acc[PW-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= MS_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      MS_IDLE: if (bus.start_mult) next_state = MS_CALC;
      MS_CALC: if (count == CNT_W'(WIDTH - 1)) next_state = MS_FIN;
      MS_FIN:  next_state = MS_IDLE;
      default: next_state = MS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
      neg    <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= (state == MS_FIN);
      case (state)
        MS_IDLE: begin
          if (bus.start_mult) begin
            // 0x8000_0000 negates to itself, which is its correct unsigned magnitude
            if (bus.mult_sign) begin
              mcand  <= bus.srca[WIDTH-1] ? (~bus.srca + WIDTH'(1)) : bus.srca;
              mplier <= bus.srcb[WIDTH-1] ? (~bus.srcb + WIDTH'(1)) : bus.srcb;
            end else begin
              mcand  <= bus.srca;
              mplier <= bus.srcb;
            end
            neg   <= bus.mult_sign & (bus.srca[WIDTH-1] ^ bus.srcb[WIDTH-1]);
            acc   <= '0;
            count <= '0;
          end
        end
        MS_CALC: begin
          acc    <= {sum, acc[WIDTH-1:1]};
          mplier <= mplier >> 1;
          count  <= count + CNT_W'(1);
        end
        MS_FIN: begin
          {hi_q, lo_q} <= neg ? (~acc + PW'(1)) : acc;
        end
        default: ;
      endcase
    end
  end

  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.mult_done = done_q;
  assign bus.mult_busy = (state != MS_IDLE);
  assign dbg_state     = state;

endmodule

// File: tb/tb_mult_unit.sv
// Directed bench for mult_unit: table of hand-computed products plus
// sequences for start-while-busy and reset in the middle of a multiply.
module tb_mult_unit;
  import mult_unit_pkg::*;

  logic        clk;
  logic        reset;
  mult_state_t dbg_state;

  mult_unit_if #(.WIDTH(32)) bus ();

  mult_unit #(.WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sign;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: pulse start for one cycle, then watch busy/done/hold until complete
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic sign, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [63:0] prev;
    int          busy_cnt;
    int          done_cnt;
    bit          held;
    prev     = {bus.hi, bus.lo};
    busy_cnt = 0;
    done_cnt = 0;
    held     = 1'b1;
    @(negedge clk);
    bus.start_mult = 1'b1;
    bus.srca       = a;
    bus.srcb       = b;
    bus.mult_sign  = sign;
    @(negedge clk);
    bus.start_mult = 1'b0;
    bus.srca       = $urandom;
    bus.srcb       = $urandom;
    while (bus.mult_busy && busy_cnt < 100) begin
      busy_cnt++;
      if (bus.mult_done) done_cnt++;
      if ({bus.hi, bus.lo} !== prev) held = 1'b0;
      @(negedge clk);
    end
    check({name, " busy_cycles"}, 64'(busy_cnt), 64'd33);
    check({name, " hold"}, 64'(held), 64'd1);
    check({name, " done_at_end"}, 64'(bus.mult_done), 64'd1);
    if (bus.mult_done) done_cnt++;
    check({name, " hi"}, 64'(bus.hi), 64'(exp_hi));
    check({name, " lo"}, 64'(bus.lo), 64'(exp_lo));
    @(negedge clk);
    if (bus.mult_done) done_cnt++;
    check({name, " done_pulses"}, 64'(done_cnt), 64'd1);
  endtask

  initial begin
    int busy_cnt;

    vecs[0] = '{32'h0000_0007, 32'h0000_0003, 1'b0, 32'h0000_0000, 32'h0000_0015};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{32'h0000_0007, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000};
    vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h0000_0001};
    vecs[5] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[6] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 32'h0000_0000, 32'h8000_0000};
    vecs[7] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000, 32'h0000_0000};

    bus.start_mult = 1'b0;
    bus.mult_sign  = 1'b0;
    bus.srca       = '0;
    bus.srcb       = '0;
    reset          = 1'b1;
    repeat (3) @(negedge clk);
    check("reset hi", 64'(bus.hi), 64'd0);
    check("reset lo", 64'(bus.lo), 64'd0);
    check("reset busy", 64'(bus.mult_busy), 64'd0);
    check("reset done", 64'(bus.mult_done), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sign,
             vecs[i].exp_hi, vecs[i].exp_lo);

    // start while busy: 5x5 request at cycle 10 of 2x3 must be dropped
    @(negedge clk);
    bus.start_mult = 1'b1;
    bus.srca       = 32'd2;
    bus.srcb       = 32'd3;
    bus.mult_sign  = 1'b0;
    @(negedge clk);
    bus.start_mult = 1'b0;
    busy_cnt = 0;
    while (bus.mult_busy && busy_cnt < 100) begin
      busy_cnt++;
      if (busy_cnt == 10) begin
        bus.start_mult = 1'b1;
        bus.srca       = 32'd5;
        bus.srcb       = 32'd5;
      end else begin
        bus.start_mult = 1'b0;
      end
      @(negedge clk);
    end
    bus.start_mult = 1'b0;
    check("busy_start busy_cycles", 64'(busy_cnt), 64'd33);
    check("busy_start hi", 64'(bus.hi), 64'd0);
    check("busy_start lo", 64'(bus.lo), 64'd6);
    @(negedge clk);
    check("busy_start no_relaunch", 64'(bus.mult_busy), 64'd0);

    // reset mid-op discards the in-flight product and clears hi/lo
    run_op("pre_reset 4x4", 32'd4, 32'd4, 1'b0, 32'd0, 32'd16);
    @(negedge clk);
    bus.start_mult = 1'b1;
    bus.srca       = 32'd9;
    bus.srcb       = 32'd9;
    @(negedge clk);
    bus.start_mult = 1'b0;
    repeat (14) @(negedge clk);
    check("mid busy_before_reset", 64'(bus.mult_busy), 64'd1);
    reset = 1'b1;
    #1;
    check("mid_reset hi", 64'(bus.hi), 64'd0);
    check("mid_reset lo", 64'(bus.lo), 64'd0);
    check("mid_reset busy", 64'(bus.mult_busy), 64'd0);
    check("mid_reset done", 64'(bus.mult_done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op("post_reset 2x2", 32'd2, 32'd2, 1'b0, 32'd0, 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
